// File: rtl/tx_batch_dispatcher_if.sv
// Scheduler-to-dispatcher bundle: accepted-ID stream in,
// batch offer and status out.
interface tx_batch_dispatcher_if #(
  parameter int BATCH_SIZE = 4,
  parameter int FIFO_DEPTH = 16
);
  logic                               transaction_accepted;
  logic [63:0]                        inserted_programID;
  logic                               has_conflict;
  logic                               batch_valid;
  logic                               batch_ready;
  logic [BATCH_SIZE*64-1:0]           batch_ids;
  logic [$clog2(BATCH_SIZE+1)-1:0]    batch_count;
  logic [15:0]                        batch_seq;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level;
  logic                               fifo_full;
  logic                               overflow;
  logic [31:0]                        conflict_count;

  modport master (
    output transaction_accepted,
    output inserted_programID,
    output has_conflict,
    output batch_ready,
    input  batch_valid,
    input  batch_ids,
    input  batch_count,
    input  batch_seq,
    input  fifo_level,
    input  fifo_full,
    input  overflow,
    input  conflict_count
  );

  modport slave (
    input  transaction_accepted,
    input  inserted_programID,
    input  has_conflict,
    input  batch_ready,
    output batch_valid,
    output batch_ids,
    output batch_count,
    output batch_seq,
    output fifo_level,
    output fifo_full,
    output overflow,
    output conflict_count
  );
endinterface

// File: rtl/tx_batch_dispatcher.sv
// Buffers accepted program IDs and offers them to the
// executor in fixed-size batches, flushing partials on timeout.
module tx_batch_dispatcher #(
  parameter int BATCH_SIZE     = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  tx_batch_dispatcher_if.slave bus
);
  localparam int CW = $clog2(BATCH_SIZE + 1);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = BATCH_SIZE * 64;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_LOAD,
    S_OFFER
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic          full_q;
  logic          ovf_q;
  logic [BW-1:0] ids_q, ids_d;
  logic [BW-1:0] slots;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] n_avail;
  logic [CW-1:0] n_pop;
  logic          valid_q, valid_d;
  logic [15:0]   seq_q, seq_d;
  logic [31:0]   confl_q, confl_d;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic          is_full;
  logic          push;
  logic          drop;
  logic          at_batch;

  // Full check is on the pre-edge level; a same-edge pop does not help.
  assign is_full  = (level_q == LW'(FIFO_DEPTH));
  assign push     = bus.transaction_accepted & ~is_full;
  assign drop     = bus.transaction_accepted & is_full;
  assign at_batch = (level_q >= LW'(BATCH_SIZE));

  assign n_avail = at_batch ? CW'(BATCH_SIZE) : CW'(level_q);
  assign n_pop   = (state_q == S_LOAD) ? n_avail : '0;

  always_comb begin
    slots = '0;
    for (int i = 0; i < BATCH_SIZE; i++) begin
      if (i < int'(n_avail)) begin
        slots[i*64 +: 64] =
          mem_q[PW'((int'(rd_q) + i) % FIFO_DEPTH)];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ids_d   = ids_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    seq_d   = seq_q;
    unique case (state_q)
      S_COLLECT: begin
        if (level_q == '0 || at_batch) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
        if (at_batch ||
            (level_q != '0 &&
             timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ids_d   = slots;
        cnt_d   = n_avail;
        valid_d = 1'b1;
        timer_d = '0;
        state_d = S_OFFER;
      end
      S_OFFER: begin
        timer_d = '0;
        if (bus.batch_ready) begin
          valid_d = 1'b0;
          seq_d   = seq_q + 16'd1;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    level_d = level_q - LW'(n_pop) + LW'(push);
    rd_d    = PW'((int'(rd_q) + int'(n_pop)) % FIFO_DEPTH);
    wr_d    = push ? PW'((int'(wr_q) + 1) % FIFO_DEPTH) : wr_q;
    confl_d = confl_q;
    if (bus.has_conflict && confl_q != '1) begin
      confl_d = confl_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= bus.inserted_programID;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      timer_q <= '0;
      level_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ids_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      seq_q   <= '0;
      confl_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      level_q <= level_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      full_q  <= (level_d == LW'(FIFO_DEPTH));
      ovf_q   <= ovf_q | drop;
      ids_q   <= ids_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      seq_q   <= seq_d;
      confl_q <= confl_d;
    end
  end

  assign bus.batch_valid    = valid_q;
  assign bus.batch_ids      = ids_q;
  assign bus.batch_count    = cnt_q;
  assign bus.batch_seq      = seq_q;
  assign bus.fifo_level     = level_q;
  assign bus.fifo_full      = full_q;
  assign bus.overflow       = ovf_q;
  assign bus.conflict_count = confl_q;
endmodule

// File: tb/tb_tx_batch_dispatcher.sv
// Bench for tx_batch_dispatcher: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_tx_batch_dispatcher;
  localparam int BS = 4;
  localparam int FD = 16;
  localparam int TO = 8;
  localparam int BW = BS * 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_batch_dispatcher_if #(.BATCH_SIZE(BS), .FIFO_DEPTH(FD)) bus();

  tx_batch_dispatcher #(
    .BATCH_SIZE(BS),
    .FIFO_DEPTH(FD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [63:0] mq[$];
  logic [63:0] mb[$];
  bit          m_ovf;
  logic [31:0] m_conf;
  logic [15:0] m_seq;
  bit          new_batch;

  function automatic logic [BW-1:0] pack();
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < mb.size(); i++) v[i*64 +: 64] = mb[i];
    return v;
  endfunction

  task automatic mreset();
    mq.delete();
    mb.delete();
    m_ovf  = 0;
    m_conf = '0;
    m_seq  = '0;
    new_batch = 0;
  endtask

  // One clock edge; the model applies the batch pop (sized on the
  // pre-edge occupancy) before the push, which is checked pre-edge.
  task automatic step(input bit acc, input logic [63:0] id,
                      input bit conf, input bit rdy);
    int pre;
    bit pre_valid;
    int n;
    bus.transaction_accepted = acc;
    bus.inserted_programID   = id;
    bus.has_conflict         = conf;
    bus.batch_ready          = rdy;
    pre       = mq.size();
    pre_valid = bus.batch_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (pre_valid && rdy) m_seq++;
    new_batch = 0;
    if (!pre_valid && bus.batch_valid) begin
      new_batch = 1;
      n = (pre < BS) ? pre : BS;
      mb.delete();
      for (int i = 0; i < n; i++) mb.push_back(mq.pop_front());
    end
    if (acc) begin
      if (pre == FD) m_ovf = 1;
      else mq.push_back(id);
    end
    if (conf && m_conf != 32'hFFFF_FFFF) m_conf++;
    bus.transaction_accepted = 0;
    bus.has_conflict         = 0;
  endtask

  task automatic test_reset();
    bus.transaction_accepted = 0;
    bus.inserted_programID   = '0;
    bus.has_conflict         = 0;
    bus.batch_ready          = 0;
    mreset();
    #22;
    n_tests++;
    if (bus.batch_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid got=%b want=0", bus.batch_valid);
    end
    n_tests++;
    if (bus.fifo_level !== '0) begin
      n_fail++; $display("FAIL rst_level got=%0d want=0", bus.fifo_level);
    end
    n_tests++;
    if (bus.fifo_full !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags got full=%b ovf=%b want 0/0",
               bus.fifo_full, bus.overflow);
    end
    n_tests++;
    if (bus.batch_seq !== '0 || bus.conflict_count !== '0) begin
      n_fail++;
      $display("FAIL rst_counters got seq=%0d conf=%0d want 0/0",
               bus.batch_seq, bus.conflict_count);
    end
    n_tests++;
    if (bus.batch_ids !== '0 || bus.batch_count !== '0) begin
      n_fail++;
      $display("FAIL rst_batch got cnt=%0d ids=%h want 0",
               bus.batch_count, bus.batch_ids);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_batch();
    logic [BW-1:0] exp;
    exp = {64'h4, 64'h3, 64'h2, 64'h1};
    for (int i = 1; i <= 4; i++) step(1, 64'(i), 0, 1);
    step(0, '0, 0, 1);
    n_tests++;
    if (bus.batch_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_lat1 got=%b want=0", bus.batch_valid);
    end
    step(0, '0, 0, 1);
    n_tests++;
    if (bus.batch_valid !== 1'b1) begin
      n_fail++; $display("FAIL full_lat2 got=%b want=1", bus.batch_valid);
    end
    n_tests++;
    if (bus.batch_ids !== exp) begin
      n_fail++; $display("FAIL full_ids got=%h want=%h", bus.batch_ids, exp);
    end
    n_tests++;
    if (bus.batch_count !== 3'd4) begin
      n_fail++; $display("FAIL full_cnt got=%0d want=4", bus.batch_count);
    end
    step(0, '0, 0, 1);
    n_tests++;
    if (bus.batch_valid !== 1'b0 || bus.batch_seq !== 16'd1 ||
        bus.fifo_level !== '0) begin
      n_fail++;
      $display("FAIL full_hs got valid=%b seq=%0d lvl=%0d want 0/1/0",
               bus.batch_valid, bus.batch_seq, bus.fifo_level);
    end
  endtask

  task automatic test_timeout();
    int e;
    int got;
    logic [BW-1:0] exp;
    exp = {64'h0, 64'h0, 64'hB, 64'hA};
    got = -1;
    step(1, 64'hA, 0, 1);
    e = cyc;
    step(1, 64'hB, 0, 1);
    for (int k = 0; k < 20 && !bus.batch_valid; k++) step(0, '0, 0, 1);
    if (bus.batch_valid) got = cyc;
    n_tests++;
    if (got != e + TO + 1) begin
      n_fail++; $display("FAIL tmo_lat got=%0d want=%0d", got, e + TO + 1);
    end
    n_tests++;
    if (bus.batch_ids !== exp || bus.batch_count !== 3'd2) begin
      n_fail++;
      $display("FAIL tmo_batch got cnt=%0d ids=%h want 2 %h",
               bus.batch_count, bus.batch_ids, exp);
    end
    step(0, '0, 0, 1);
  endtask

  task automatic test_overflow();
    logic [BW-1:0] exp;
    bit seen;
    exp = {64'h103, 64'h102, 64'h101, 64'h100};
    seen = 0;
    for (int i = 0; i < 20; i++) step(1, 64'h100 + 64'(i), 0, 0);
    n_tests++;
    if (bus.batch_valid !== 1'b1 || bus.batch_ids !== exp) begin
      n_fail++;
      $display("FAIL ovf_hold got v=%b ids=%h want 1 %h",
               bus.batch_valid, bus.batch_ids, exp);
    end
    n_tests++;
    if (bus.fifo_level !== 5'd16 || bus.fifo_full !== 1'b1 ||
        bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full got lvl=%0d full=%b ovf=%b want 16/1/0",
               bus.fifo_level, bus.fifo_full, bus.overflow);
    end
    step(1, 64'h114, 0, 0);
    n_tests++;
    if (bus.overflow !== 1'b1 || bus.fifo_level !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_drop got ovf=%b lvl=%0d want 1/16",
               bus.overflow, bus.fifo_level);
    end
    for (int k = 0;
         k < 200 && (bus.batch_valid || bus.fifo_level != 0); k++) begin
      step(0, '0, 0, 1);
      if (new_batch) begin
        n_tests++;
        if (bus.batch_ids !== pack() ||
            bus.batch_count !== 3'(mb.size())) begin
          n_fail++;
          $display("FAIL ovf_drain got cnt=%0d ids=%h want %0d %h",
                   bus.batch_count, bus.batch_ids, mb.size(), pack());
        end
        for (int i = 0; i < BS; i++)
          if (bus.batch_ids[i*64 +: 64] == 64'h114) seen = 1;
      end
    end
    n_tests++;
    if (seen || bus.fifo_level !== '0 || bus.batch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_end got seen114=%0d lvl=%0d v=%b want 0/0/0",
               seen, bus.fifo_level, bus.batch_valid);
    end
  endtask

  task automatic test_conflict();
    step(0, '0, 1, 0);
    step(1, 64'h55, 1, 0);
    step(0, '0, 1, 0);
    n_tests++;
    if (bus.conflict_count !== 32'd3 || bus.conflict_count !== m_conf) begin
      n_fail++;
      $display("FAIL conf_cnt got=%0d want=3", bus.conflict_count);
    end
    for (int k = 0; k < 20 && !bus.batch_valid; k++) step(0, '0, 0, 1);
    n_tests++;
    if (bus.batch_valid !== 1'b1 || bus.batch_count !== 3'd1 ||
        bus.batch_ids[63:0] !== 64'h55) begin
      n_fail++;
      $display("FAIL conf_batch got v=%b cnt=%0d id0=%h want 1/1/55",
               bus.batch_valid, bus.batch_count, bus.batch_ids[63:0]);
    end
    step(0, '0, 0, 1);
  endtask

  task automatic test_reset_mid();
    int e;
    int got;
    got = -1;
    for (int i = 0; i < 4; i++) step(1, 64'h201 + 64'(i), 0, 0);
    for (int k = 0; k < 5 && !bus.batch_valid; k++) step(0, '0, 0, 0);
    n_tests++;
    if (bus.batch_valid !== 1'b1 || bus.batch_count !== 3'd4) begin
      n_fail++;
      $display("FAIL rmid_pre got v=%b cnt=%0d want 1/4",
               bus.batch_valid, bus.batch_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.batch_valid !== 1'b0 || bus.fifo_level !== '0 ||
        bus.batch_seq !== '0 || bus.overflow !== 1'b0 ||
        bus.conflict_count !== '0) begin
      n_fail++;
      $display("FAIL rmid_async got v=%b lvl=%0d seq=%0d ovf=%b conf=%0d",
               bus.batch_valid, bus.fifo_level, bus.batch_seq,
               bus.overflow, bus.conflict_count);
    end
    mreset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 64'h77, 0, 1);
    e = cyc;
    for (int k = 0; k < 20 && !bus.batch_valid; k++) step(0, '0, 0, 1);
    if (bus.batch_valid) got = cyc;
    n_tests++;
    if (got != e + TO + 1) begin
      n_fail++; $display("FAIL rmid_lat got=%0d want=%0d", got, e + TO + 1);
    end
    n_tests++;
    if (bus.batch_count !== 3'd1 || bus.batch_ids[63:0] !== 64'h77) begin
      n_fail++;
      $display("FAIL rmid_batch got cnt=%0d id0=%h want 1/77",
               bus.batch_count, bus.batch_ids[63:0]);
    end
    step(0, '0, 0, 1);
  endtask

  task automatic test_random();
    bit acc, conf, rdy;
    logic [63:0] id;
    int bad;
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      acc  = ($urandom_range(0, 1) == 1);
      conf = ($urandom_range(0, 3) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      id   = {$urandom, $urandom};
      step(acc, id, conf, rdy);
      n_tests++;
      if (bus.fifo_level !== 5'(mq.size()) ||
          bus.fifo_full !== (mq.size() == FD) ||
          bus.overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL rnd_fifo@%0d got lvl=%0d full=%b ovf=%b want %0d %0b %0b",
                 cyc, bus.fifo_level, bus.fifo_full, bus.overflow,
                 mq.size(), mq.size() == FD, m_ovf);
      end
      n_tests++;
      if (bus.batch_seq !== m_seq || bus.conflict_count !== m_conf) begin
        n_fail++;
        $display("FAIL rnd_cnt@%0d got seq=%0d conf=%0d want %0d %0d",
                 cyc, bus.batch_seq, bus.conflict_count, m_seq, m_conf);
      end
      if (bus.batch_valid) begin
        n_tests++;
        if (bus.batch_ids !== pack() ||
            bus.batch_count !== 3'(mb.size())) begin
          n_fail++;
          $display("FAIL rnd_batch@%0d got cnt=%0d ids=%h want %0d %h",
                   cyc, bus.batch_count, bus.batch_ids, mb.size(), pack());
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_batch();
    test_timeout();
    test_overflow();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
